// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the wait-state data-memory responder:
// FSM state encoding, default base address and word size.
package dmem_responder_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;
    localparam int          WORD_BYTES     = 4;

endpackage

// File: rtl/dmem_responder_array.sv
// Word RAM behind the DMEM responder: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module dmem_array #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    // Store lands in the array at the rising edge when the write strobe is up.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state DMEM slave for the pipeline CPU. Each access occupies
// LATENCY+1 cycles with stall raised for the first LATENCY of them; data
// is returned (load) or written (store) in the final, stall-free cycle.
// Optional protocol checker enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 11,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = DMEM_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] DMEM_addr,
    input  logic [31:0] DMEM_data,
    input  logic        DMEM_wena,
    input  logic        DMEM_rena,
    output logic [31:0] DMEM_out,
    output logic        stall,
    output logic        err
);

    localparam int                CNT_W      = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(LATENCY);
    localparam logic [31:0]       SPAN_BYTES = 32'(WORD_BYTES) << DEPTH_LOG2;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              rena_q, rena_d;
    logic              wena_q, wena_d;

    logic              req;
    logic              complete;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_data;
    logic              sel_rena;
    logic              sel_wena;
    logic [31:0]       sel_off;
    logic              sel_in_range;
    logic [DEPTH_LOG2-1:0] sel_idx;
    logic              is_load;
    logic              is_store;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    assign req = DMEM_rena | DMEM_wena;

    // With no wait states the live request is serviced directly; otherwise the latched copy is.
    always_comb begin
        if (LATENCY == 0) begin
            sel_addr = DMEM_addr;
            sel_data = DMEM_data;
            sel_rena = DMEM_rena;
            sel_wena = DMEM_wena;
            complete = (state_q == S_IDLE) && req;
        end else begin
            sel_addr = addr_q;
            sel_data = data_q;
            sel_rena = rena_q;
            sel_wena = wena_q;
            complete = (state_q == S_WAIT) && (cnt_q == CNT_LAST);
        end
    end

    // Word index drops the byte offset; the full unsigned offset decides range.
    assign sel_off      = sel_addr - BASE_ADDR;
    assign sel_in_range = sel_off < SPAN_BYTES;
    assign sel_idx      = sel_off[DEPTH_LOG2+1:2];

    // A simultaneous load and store request is treated purely as a store.
    assign is_store = sel_wena;
    assign is_load  = sel_rena & ~sel_wena;

    assign mem_we   = !rst && complete && is_store && sel_in_range;

    dmem_array #(
        .ADDR_W (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (sel_idx),
        .wdata (sel_data),
        .raddr (sel_idx),
        .rdata (mem_rdata)
    );

    assign DMEM_out = (!rst && complete && is_load && sel_in_range) ? mem_rdata : 32'h0;

    assign stall = !rst &&
                   (((state_q == S_IDLE) && req && (LATENCY != 0)) ||
                    ((state_q == S_WAIT) && (cnt_q != CNT_LAST)));

    // Next-state logic: accept in IDLE, count wait states, return to IDLE after completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rena_d  = rena_q;
        wena_d  = wena_q;
        case (state_q)
            S_IDLE: begin
                if (req && (LATENCY != 0)) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(1);
                    addr_d  = DMEM_addr;
                    data_d  = DMEM_data;
                    rena_d  = DMEM_rena;
                    wena_d  = DMEM_wena;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and request latches; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            rena_q  <= 1'b0;
            wena_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rena_q  <= rena_d;
            wena_q  <= wena_d;
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    logic        err_q, err_d;
    logic [31:0] live_off;
    logic        live_in_range;

    assign live_off      = DMEM_addr - BASE_ADDR;
    assign live_in_range = live_off < SPAN_BYTES;

    // Flag bad requests at acceptance and any request that moves while held in WAIT.
    always_comb begin
        err_d = err_q;
        if ((state_q == S_IDLE) && req) begin
            if ((DMEM_rena && DMEM_wena) || !live_in_range || (DMEM_addr[1:0] != 2'b00)) begin
                err_d = 1'b1;
            end
        end
        if (state_q == S_WAIT) begin
            if ((DMEM_addr != addr_q) || (DMEM_data != data_q) ||
                (DMEM_rena != rena_q) || (DMEM_wena != wena_q)) begin
                err_d = 1'b1;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance carries most
// vectors, a LATENCY=0 instance covers the single-cycle mode. Both share
// the same request inputs.
module tb_dmem_responder;

`ifdef DMEM_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] dmemAddr;
    logic [31:0] dmemData;
    logic        dmemWena;
    logic        dmemRena;
    logic [31:0] out2;
    logic        stall2;
    logic        err2;
    logic [31:0] out0;
    logic        stall0;
    logic        err0;

    int checkCount = 0;
    int errorCount = 0;

    dmem_responder #(
        .DEPTH_LOG2 (11),
        .LATENCY    (2),
        .BASE_ADDR  (32'h1001_0000)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .DMEM_addr (dmemAddr),
        .DMEM_data (dmemData),
        .DMEM_wena (dmemWena),
        .DMEM_rena (dmemRena),
        .DMEM_out  (out2),
        .stall     (stall2),
        .err       (err2)
    );

    dmem_responder #(
        .DEPTH_LOG2 (11),
        .LATENCY    (0),
        .BASE_ADDR  (32'h1001_0000)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .DMEM_addr (dmemAddr),
        .DMEM_data (dmemData),
        .DMEM_wena (dmemWena),
        .DMEM_rena (dmemRena),
        .DMEM_out  (out0),
        .stall     (stall0),
        .err       (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drives one access on the LATENCY=2 instance starting just after a rising
    // edge, counts stalled cycles and captures DMEM_out in the completion cycle.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                 input logic [31:0] data, input bit hold,
                                 output int stallCycles, output logic [31:0] loadData);
        bit done;
        dmemWena    = wr;
        dmemRena    = rd;
        dmemAddr    = addr;
        dmemData    = data;
        stallCycles = 0;
        loadData    = 32'h0;
        done        = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            if (stall2) begin
                stallCycles++;
            end else begin
                done     = 1'b1;
                loadData = out2;
            end
        end
        if (!done) begin
            checkOutput("stall_timeout", 32'h1, 32'h0);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            dmemWena = 1'b0;
            dmemRena = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          sc;
        logic [31:0] ld;

        rst      = 1'b1;
        dmemAddr = 32'h0;
        dmemData = 32'h0;
        dmemWena = 1'b0;
        dmemRena = 1'b0;
        #1;
        checkOutput("reset_stall", 32'(stall2), 32'h0);
        checkOutput("reset_out", out2, 32'h0);
        checkOutput("reset_err", 32'(err2), 32'h0);
        checkOutput("reset_stall_l0", 32'(stall0), 32'h0);
        checkOutput("reset_err_l0", 32'(err0), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] store then load with two wait states");
        applyStimulus(1'b1, 1'b0, 32'h1001_0010, 32'hDEAD_BEEF, 1'b0, sc, ld);
        checkOutput("store_stall_cycles", 32'(sc), 32'd2);
        checkOutput("store_out", ld, 32'h0);
        @(negedge clk);
        checkOutput("idle_stall", 32'(stall2), 32'h0);
        checkOutput("idle_out", out2, 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 32'h1001_0010, 32'h0, 1'b0, sc, ld);
        checkOutput("load_stall_cycles", 32'(sc), 32'd2);
        checkOutput("load_data", ld, 32'hDEAD_BEEF);

        $display("[TB] boundary accesses");
        applyStimulus(1'b1, 1'b0, 32'h1001_0000, 32'hAAAA_0000, 1'b0, sc, ld);
        applyStimulus(1'b1, 1'b0, 32'h1001_1FFC, 32'hCAFE_F00D, 1'b0, sc, ld);
        applyStimulus(1'b0, 1'b1, 32'h1001_1FFC, 32'h0, 1'b0, sc, ld);
        checkOutput("last_word_load", ld, 32'hCAFE_F00D);
        checkOutput("err_clean", 32'(err2), 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h1001_2000, 32'h1111_1111, 1'b0, sc, ld);
        checkOutput("oor_store_stall_cycles", 32'(sc), 32'd2);
        checkOutput("oor_store_err", 32'(err2), 32'(ERR_EN));
        applyStimulus(1'b0, 1'b1, 32'h1001_2000, 32'h0, 1'b0, sc, ld);
        checkOutput("oor_load_data", ld, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h1001_0000, 32'h0, 1'b0, sc, ld);
        checkOutput("word0_untouched", ld, 32'hAAAA_0000);

        $display("[TB] back-to-back loads");
        applyStimulus(1'b1, 1'b0, 32'h1001_0004, 32'h0BAD_F00D, 1'b0, sc, ld);
        applyStimulus(1'b0, 1'b1, 32'h1001_0004, 32'h0, 1'b1, sc, ld);
        checkOutput("b2b_first_stall", 32'(sc), 32'd2);
        checkOutput("b2b_first_data", ld, 32'h0BAD_F00D);
        applyStimulus(1'b0, 1'b1, 32'h1001_0004, 32'h0, 1'b0, sc, ld);
        checkOutput("b2b_second_stall", 32'(sc), 32'd2);
        checkOutput("b2b_second_data", ld, 32'h0BAD_F00D);

        $display("[TB] reset during a pending store");
        dmemWena = 1'b1;
        dmemRena = 1'b0;
        dmemAddr = 32'h1001_0010;
        dmemData = 32'h1234_5678;
        @(negedge clk);
        checkOutput("abort_pre_stall", 32'(stall2), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("abort_wait_stall", 32'(stall2), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_stall", 32'(stall2), 32'h0);
        checkOutput("abort_out", out2, 32'h0);
        checkOutput("abort_err", 32'(err2), 32'h0);
        dmemWena = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h1001_0010, 32'h0, 1'b0, sc, ld);
        checkOutput("abort_word_kept", ld, 32'hDEAD_BEEF);

        $display("[TB] data changed while stalled");
        dmemWena = 1'b1;
        dmemRena = 1'b0;
        dmemAddr = 32'h1001_0020;
        dmemData = 32'h0000_0055;
        @(posedge clk);
        #1;
        dmemData = 32'h0000_0066;
        @(posedge clk);
        #1;
        checkOutput("proto_err_set", 32'(err2), 32'(ERR_EN));
        @(posedge clk);
        #1;
        dmemWena = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("proto_err_hold", 32'(err2), 32'(ERR_EN));
        applyStimulus(1'b0, 1'b1, 32'h1001_0020, 32'h0, 1'b0, sc, ld);
        checkOutput("proto_latched_data", ld, 32'h0000_0055);
        rst = 1'b1;
        #1;
        checkOutput("proto_err_clear", 32'(err2), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single-cycle instance");
        for (int i = 0; i < 2; i++) begin
            dmemWena = 1'b1;
            dmemRena = 1'b0;
            dmemAddr = 32'h1001_0000;
            dmemData = 32'h0000_0005;
            @(negedge clk);
            checkOutput("l0_store_stall", 32'(stall0), 32'h0);
            checkOutput("l0_store_out", out0, 32'h0);
            @(posedge clk);
            #1;
            dmemWena = 1'b0;
            dmemRena = 1'b1;
            @(negedge clk);
            checkOutput("l0_load_stall", 32'(stall0), 32'h0);
            checkOutput("l0_load_data", out0, 32'h0000_0005);
            @(posedge clk);
            #1;
        end
        dmemRena = 1'b0;
        @(negedge clk);
        checkOutput("l0_idle_out", out0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
